// File: rtl/int_wakeup_scheduler.sv
// int_wakeup_scheduler: CTB wakeup timing and writeback-slot reservation for the 3 integer pipes.
// Defining WAKEUP_SCHED_PERF_EN adds the per-pipe stall_cycles counters.
`ifndef ISSUE_WIDTH_INT
`define ISSUE_WIDTH_INT 3
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module int_wakeup_scheduler #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic                                                flush,
  input  logic [`ISSUE_WIDTH_INT-1:0]                         issue_valid,
  input  logic [`ISSUE_WIDTH_INT-1:0]                         issue_rd_valid,
  input  logic [`ISSUE_WIDTH_INT-1:0][`PRF_INT_INDEX_SIZE-1:0] issue_prd,
  input  logic                                                issue_is_mul,
  input  logic                                                issue_is_div,
  output logic [`ISSUE_WIDTH_INT-1:0]                         ctb_valid,
  output logic [`ISSUE_WIDTH_INT-1:0][`PRF_INT_INDEX_SIZE-1:0] ctb_prf_int_index,
  output logic [`ISSUE_WIDTH_INT-1:0]                         ex_busy,
  output logic                                                conflict_err
`ifdef WAKEUP_SCHED_PERF_EN
  ,
  output logic [`ISSUE_WIDTH_INT-1:0][31:0]                   stall_cycles
`endif
);

  localparam int NL = `ISSUE_WIDTH_INT;
  localparam int TW = `PRF_INT_INDEX_SIZE;
  localparam int CW = $clog2(DIV_LAT);

  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_e;

  div_state_e                          div_state_q;
  logic [CW-1:0]                       div_cnt_q;
  logic [NL-1:0][DIV_LAT-1:0]          pend_q, pend_d;
  logic [NL-1:0][DIV_LAT-1:0][TW-1:0]  tag_q, tag_d;
  logic                                conflict_q, conflict_d;
  logic                                mul_div_clash;
  logic [NL-1:0]                       accept, writes;
  logic [CW-1:0]                       mul_slot, div_slot;

  // Entry k of pend/tag is the broadcast due k cycles from now; a uop of latency L lands in slot L-1.
  always_comb begin
    mul_div_clash = issue_is_mul & issue_is_div;
    accept        = issue_valid & ~ex_busy & {NL{~flush}};
    if (mul_div_clash) begin
      accept[1] = 1'b0;
      accept[2] = 1'b0;
    end
    writes     = accept & issue_rd_valid;
    conflict_d = conflict_q | (|(issue_valid & ex_busy)) | mul_div_clash
               | (issue_is_mul & ~issue_valid[1]) | (issue_is_div & ~issue_valid[2]);
    mul_slot   = issue_is_mul ? CW'(MUL_LAT - 1) : '0;
    div_slot   = issue_is_div ? CW'(DIV_LAT - 1) : '0;
    pend_d     = '0;
    tag_d      = '0;
    for (int p = 0; p < NL; p++) begin
      for (int k = 0; k < DIV_LAT - 1; k++) begin
        pend_d[p][k] = pend_q[p][k+1];
        tag_d[p][k]  = tag_q[p][k+1];
      end
    end
    if (writes[0]) begin
      pend_d[0][0] = 1'b1;
      tag_d[0][0]  = issue_prd[0];
    end
    if (writes[1]) begin
      pend_d[1][mul_slot] = 1'b1;
      tag_d[1][mul_slot]  = issue_prd[1];
    end
    if (writes[2]) begin
      pend_d[2][div_slot] = 1'b1;
      tag_d[2][div_slot]  = issue_prd[2];
    end
    if (flush) begin
      pend_d = '0;
      tag_d  = '0;
    end
  end

  // The divider stays BUSY until the cycle its result would broadcast, even without a destination.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q      <= '0;
      tag_q       <= '0;
      conflict_q  <= 1'b0;
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
    end else begin
      pend_q     <= pend_d;
      tag_q      <= tag_d;
      conflict_q <= conflict_d;
      if (flush) begin
        div_state_q <= DIV_IDLE;
        div_cnt_q   <= '0;
      end else begin
        case (div_state_q)
          DIV_IDLE: begin
            if (accept[2] && issue_is_div) begin
              div_state_q <= DIV_BUSY;
              div_cnt_q   <= CW'(DIV_LAT - 1);
            end
          end
          DIV_BUSY: begin
            if (div_cnt_q == CW'(1)) begin
              div_state_q <= DIV_IDLE;
              div_cnt_q   <= '0;
            end else begin
              div_cnt_q <= div_cnt_q - CW'(1);
            end
          end
          default: div_state_q <= DIV_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NL; p++) begin
      ctb_valid[p]         = pend_q[p][0];
      ctb_prf_int_index[p] = pend_q[p][0] ? tag_q[p][0] : '0;
      ex_busy[p]           = pend_q[p][1];
    end
    ex_busy[2] = pend_q[2][1] | (div_state_q == DIV_BUSY);
  end

  assign conflict_err = conflict_q;

`ifdef WAKEUP_SCHED_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
    end else begin
      for (int p = 0; p < NL; p++) begin
        if (ex_busy[p] && (stall_cycles[p] != 32'hFFFF_FFFF)) begin
          stall_cycles[p] <= stall_cycles[p] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_int_wakeup_scheduler.sv
// Testbench for int_wakeup_scheduler: directed wakeup scenarios, then randomized traffic
// compared each cycle against a broadcast-calendar reference model.
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module tb_int_wakeup_scheduler;

  localparam int TW      = `PRF_INT_INDEX_SIZE;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 16;
  localparam int R       = 64;

  logic                 clock = 1'b0;
  logic                 reset, flush;
  logic [2:0]           issue_valid, issue_rd_valid;
  logic [2:0][TW-1:0]   issue_prd;
  logic                 issue_is_mul, issue_is_div;
  logic [2:0]           ctb_valid, ex_busy;
  logic [2:0][TW-1:0]   ctb_prf_int_index;
  logic                 conflict_err;
`ifdef WAKEUP_SCHED_PERF_EN
  logic [2:0][31:0]     stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Calendar of expected broadcasts, indexed by absolute cycle modulo R.
  logic [2:0]         expV [R];
  logic [2:0][TW-1:0] expT [R];
  int                 divLastBusy = -1;
  logic               expConflict = 1'b0;
  longint             expStall [3];

  int_wakeup_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .issue_valid       (issue_valid),
    .issue_rd_valid    (issue_rd_valid),
    .issue_prd         (issue_prd),
    .issue_is_mul      (issue_is_mul),
    .issue_is_div      (issue_is_div),
    .ctb_valid         (ctb_valid),
    .ctb_prf_int_index (ctb_prf_int_index),
    .ex_busy           (ex_busy),
    .conflict_err      (conflict_err)
`ifdef WAKEUP_SCHED_PERF_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [2:0][TW-1:0] pk(input int a2, input int a1, input int a0);
    logic [2:0][TW-1:0] r;
    r[2] = TW'(a2);
    r[1] = TW'(a1);
    r[0] = TW'(a0);
    return r;
  endfunction

  // A pipe is busy if its next writeback slot already holds a broadcast, or the divider is mid-op.
  function automatic logic modelBusy(input int p);
    logic b;
    b = expV[(cyc + 1) % R][p];
    if (p == 2 && cyc <= divLastBusy) b = 1'b1;
    return b;
  endfunction

  task automatic clearModel();
    for (int r = 0; r < R; r++) begin
      expV[r] = '0;
      expT[r] = '0;
    end
    divLastBusy = -1;
  endtask

  task automatic compare(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic checkOutput();
    int r;
    logic [2:0] eb;
    logic [2:0][TW-1:0] et;
    r = cyc % R;
    for (int p = 0; p < 3; p++) begin
      eb[p] = modelBusy(p);
      et[p] = expV[r][p] ? expT[r][p] : '0;
    end
    compare("ctb_valid", 64'(ctb_valid), 64'(expV[r]));
    compare("ctb_tag", 64'(ctb_prf_int_index), 64'(et));
    compare("ex_busy", 64'(ex_busy), 64'(eb));
    compare("conflict_err", 64'(conflict_err), 64'(expConflict));
`ifdef WAKEUP_SCHED_PERF_EN
    for (int p = 0; p < 3; p++) compare("stall_cycles", 64'(stall_cycles[p]), 64'(expStall[p]));
`endif
  endtask

  // Checks the current cycle, drives one cycle of issue, and advances the model by one cycle.
  task automatic applyStimulus(input logic [2:0] v, input logic [2:0] rdv,
                               input logic [2:0][TW-1:0] prd, input logic mul,
                               input logic div, input logic fl);
    logic [2:0] busy, acc;
    int lat;
    checkOutput();
    for (int p = 0; p < 3; p++) busy[p] = modelBusy(p);
    issue_valid    = v;
    issue_rd_valid = rdv;
    issue_prd      = prd;
    issue_is_mul   = mul;
    issue_is_div   = div;
    flush          = fl;
    for (int p = 0; p < 3; p++) expStall[p] += longint'(busy[p]);
    if ((|(v & busy)) || (mul && div) || (mul && !v[1]) || (div && !v[2])) expConflict = 1'b1;
    expV[cyc % R] = '0;
    expT[cyc % R] = '0;
    if (fl) begin
      clearModel();
    end else begin
      acc = v & ~busy;
      if (mul && div) begin
        acc[1] = 1'b0;
        acc[2] = 1'b0;
      end
      for (int p = 0; p < 3; p++) begin
        if (acc[p]) begin
          lat = 1;
          if (p == 1 && mul) lat = MUL_LAT;
          if (p == 2 && div) begin
            lat = DIV_LAT;
            divLastBusy = cyc + DIV_LAT - 1;
          end
          if (rdv[p]) begin
            expV[(cyc + lat) % R][p] = 1'b1;
            expT[(cyc + lat) % R][p] = prd[p];
          end
        end
      end
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(3'b000, 3'b000, pk(0, 0, 0), 1'b0, 1'b0, 1'b0);
  endtask

  // Reset is held alongside a flush and a full conflicting issue to show it dominates both.
  task automatic doReset();
    reset          = 1'b1;
    flush          = 1'b1;
    issue_valid    = 3'b111;
    issue_rd_valid = 3'b111;
    issue_prd      = pk(1, 2, 3);
    issue_is_mul   = 1'b1;
    issue_is_div   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cyc++;
    reset          = 1'b0;
    flush          = 1'b0;
    issue_valid    = '0;
    issue_rd_valid = '0;
    issue_prd      = '0;
    issue_is_mul   = 1'b0;
    issue_is_div   = 1'b0;
    clearModel();
    expConflict = 1'b0;
    for (int p = 0; p < 3; p++) expStall[p] = 0;
  endtask

  initial begin
    logic [2:0] v, busy;
    logic mul, div, fl;

    for (int p = 0; p < 3; p++) expStall[p] = 0;
    clearModel();
    doReset();
    compare("reset_ctb_valid", 64'(ctb_valid), 64'd0);
    compare("reset_ex_busy", 64'(ex_busy), 64'd0);

    // ALU on all three lanes
    applyStimulus(3'b111, 3'b111, pk(7, 6, 5), 1'b0, 1'b0, 1'b0);
    compare("alu_valid", 64'(ctb_valid), 64'h7);
    compare("alu_tags", 64'(ctb_prf_int_index), 64'(pk(7, 6, 5)));
    compare("alu_busy", 64'(ex_busy), 64'h0);
    idle(2);

    // Back-to-back IMUL on lane 1
    applyStimulus(3'b010, 3'b010, pk(0, 9, 0), 1'b1, 1'b0, 1'b0);
    compare("mul_busy_t1", 64'(ex_busy), 64'h0);
    applyStimulus(3'b010, 3'b010, pk(0, 10, 0), 1'b1, 1'b0, 1'b0);
    compare("mul_busy_t2", 64'(ex_busy), 64'h2);
    idle(1);
    compare("mul_ctb_t3", 64'(ctb_prf_int_index), 64'(pk(0, 9, 0)));
    idle(1);
    compare("mul_ctb_t4", 64'(ctb_prf_int_index), 64'(pk(0, 10, 0)));
    compare("mul_busy_t4", 64'(ex_busy), 64'h0);
    idle(2);

    // IDIV then ALU on lane 2 exactly when the divide broadcasts
    applyStimulus(3'b100, 3'b100, pk(12, 0, 0), 1'b0, 1'b1, 1'b0);
    compare("div_busy_t1", 64'(ex_busy), 64'h4);
    idle(14);
    compare("div_busy_t15", 64'(ex_busy), 64'h4);
    idle(1);
    compare("div_busy_t16", 64'(ex_busy), 64'h0);
    compare("div_ctb_t16", 64'(ctb_prf_int_index), 64'(pk(12, 0, 0)));
    applyStimulus(3'b100, 3'b100, pk(13, 0, 0), 1'b0, 1'b0, 1'b0);
    compare("alu_after_div", 64'(ctb_prf_int_index), 64'(pk(13, 0, 0)));
    idle(2);

    // Flush mid-divide
    applyStimulus(3'b100, 3'b100, pk(14, 0, 0), 1'b0, 1'b1, 1'b0);
    idle(4);
    applyStimulus(3'b000, 3'b000, pk(0, 0, 0), 1'b0, 1'b0, 1'b1);
    compare("flush_busy", 64'(ex_busy), 64'h0);
    idle(15);

    // Conflict: ALU on lane 2 while the divider is busy
    applyStimulus(3'b100, 3'b100, pk(20, 0, 0), 1'b0, 1'b1, 1'b0);
    idle(1);
    applyStimulus(3'b100, 3'b100, pk(3, 0, 0), 1'b0, 1'b0, 1'b0);
    compare("conflict_set", 64'(conflict_err), 64'h1);
    idle(16);
    compare("conflict_sticky", 64'(conflict_err), 64'h1);
    applyStimulus(3'b110, 3'b110, pk(4, 8, 0), 1'b1, 1'b1, 1'b0);
    idle(3);

    doReset();
    compare("reset_conflict", 64'(conflict_err), 64'h0);

    // Legal randomized traffic with occasional flushes
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 3; p++) busy[p] = modelBusy(p);
      v   = 3'($urandom) & ~busy;
      mul = v[1] & 1'($urandom);
      div = v[2] & ($urandom_range(0, 5) == 0);
      if (mul && div) div = 1'b0;
      fl  = ($urandom_range(0, 49) == 0);
      applyStimulus(v, 3'($urandom), pk($urandom, $urandom, $urandom), mul, div, fl);
    end
    compare("legal_no_conflict", 64'(conflict_err), 64'h0);

    doReset();

    // Unconstrained randomized traffic, including protocol violations
    for (int i = 0; i < 800; i++) begin
      v   = 3'($urandom);
      mul = 1'($urandom);
      div = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 29) == 0);
      applyStimulus(v, 3'($urandom), pk($urandom, $urandom, $urandom), mul, div, fl);
    end
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
